// File: rtl/rr_flag_arbiter.sv
// Round-robin arbiter with sticky pending flags and one owner at a time.
// Optional forced release of long-held grants when RR_ARB_TIMEOUT_EN is defined.
module rr_flag_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic [N-1:0]   pending,
  output logic           timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Elaboration-time parameter sanity checks
  if (IDW < $clog2(N)) begin : g_bad_idw
    $error("rr_flag_arbiter: IDW too narrow for N");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_flag_arbiter: MAX_HOLD must be at least 1");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           timeout_q, timeout_d;
  logic           force_rel;

  logic [N-1:0]   arb_vec;
  logic [N-1:0]   shifted;
  logic           sel_hit;
  int             sel_idx;
  logic [N-1:0]   sel_onehot;
  logic [IDW-1:0] sel_id;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Count hold cycles; eviction fires on the edge the count would reach MAX_HOLD
  assign force_rel = (state_q == GRANT) && !done &&
                     (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  // Arbitrate on the registered flags; the current owner is masked while it releases
  always_comb begin
    arb_vec = pending_q;
    if (state_q == GRANT) begin
      arb_vec = pending_q & ~grant_q;
    end
  end

  // Rotating first-set search starting just after the last owner
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 0;
    shifted = '0;
    for (int k = 1; k <= int'(N); k++) begin
      shifted = arb_vec >> ((int'(last_id_q) + k) % int'(N));
      if (!sel_hit && shifted[0]) begin
        sel_hit = 1'b1;
        sel_idx = (int'(last_id_q) + k) % int'(N);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      sel_onehot[i] = sel_hit && (i == sel_idx);
    end
    sel_id = IDW'(sel_idx);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    pending_d  = pending_q | req;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d     = hold_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sel_hit) begin
          state_d    = GRANT;
          grant_d    = sel_onehot;
          grant_id_d = sel_id;
          last_id_d  = sel_id;
          busy_d     = 1'b1;
          pending_d  = pending_d & ~sel_onehot;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d     = '0;
`endif
        end
      end

      GRANT: begin
        if (done || force_rel) begin
          if (sel_hit) begin
            grant_d    = sel_onehot;
            grant_id_d = sel_id;
            last_id_d  = sel_id;
            pending_d  = pending_d & ~sel_onehot;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
          // Evicted owner goes to the back of the rotation
          if (force_rel) begin
            timeout_d = 1'b1;
            pending_d = pending_d | grant_q;
          end
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IDW'(N - 1);
      busy_q     <= 1'b0;
      pending_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign timeout  = timeout_q;

endmodule
